io_port_bank: RTL and testbench

Parametrised port-mapped I/O block between the processor core and the outside world; N ports of W bits each direction.
Output ports are registered, with a per-port update pulse; input ports are latched on strobe, with sticky valid/overrun flags.
Adds an in-hardware halt detector on a designated output port, plus a cycle watchdog, so that any bench or top level can stop on `halted` or `timeout` instead of polling a raw port bit.

---
 rtl/io_port_bank.sv | 171 +++++++++++++++++
 tb/tb_io_port_bank.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// Port-mapped I/O bank: registered output ports with update pulses, strobed input
// latches with valid/overrun flags, a program-end halt detector and a cycle watchdog.
module io_port_bank #(
  parameter int N_PORTS     = 16,
  parameter int DATA_W      = 8,
  parameter int HALT_PORT   = 15,
  parameter int WDOG_CYCLES = 100000,
  parameter int ADDR_W      = $clog2(N_PORTS + 2)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic                        cpu_wr_en,
  input  logic [DATA_W-1:0]           cpu_wr_data,
  input  logic                        cpu_rd_en,
  output logic [DATA_W-1:0]           cpu_rd_data,
  output logic                        cpu_rd_valid,
  input  logic [N_PORTS*DATA_W-1:0]   port_in_data,
  input  logic [N_PORTS-1:0]          port_in_strobe,
  output logic [N_PORTS*DATA_W-1:0]   port_out_data,
  output logic [N_PORTS-1:0]          port_out_update,
  output logic                        halted,
  output logic                        timeout
);

  localparam int VALID_W = (N_PORTS < DATA_W) ? N_PORTS : DATA_W;
  localparam int WD_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_PORTS);
  localparam logic [ADDR_W-1:0] VALID_ADDR  = ADDR_W'(N_PORTS + 1);
  localparam logic [ADDR_W-1:0] HALT_ADDR   = ADDR_W'(HALT_PORT);
  localparam logic [WD_W-1:0]   WD_LAST     = (WDOG_CYCLES > 0) ? WD_W'(WDOG_CYCLES - 1) : '0;

  logic                      wr_ok;
  logic [N_PORTS-1:0]        wr_sel;
  logic [N_PORTS-1:0]        rd_sel;
  logic                      status_wr;
  logic                      halt_req;

  logic [N_PORTS*DATA_W-1:0] in_latch;
  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        overrun;
  logic [N_PORTS-1:0]        valid_nxt;
  logic [N_PORTS-1:0]        overrun_nxt;

  logic [DATA_W-1:0]         status_word;
  logic [DATA_W-1:0]         valid_word;
  logic [DATA_W-1:0]         rd_word;

  logic [WD_W-1:0]           wd_count;
  logic                      wd_run;

  // Address decode; once halted, every CPU write is dropped here.
  always_comb begin
    wr_ok     = cpu_wr_en && !halted;
    wr_sel    = '0;
    rd_sel    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      wr_sel[k] = wr_ok && (cpu_addr == ADDR_W'(k));
      rd_sel[k] = cpu_rd_en && (cpu_addr == ADDR_W'(k));
    end
    status_wr = wr_ok && (cpu_addr == STATUS_ADDR);
    halt_req  = wr_ok && (cpu_addr == HALT_ADDR) && cpu_wr_data[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_data   <= '0;
      port_out_update <= '0;
    end else begin
      port_out_update <= wr_sel;
      for (int k = 0; k < N_PORTS; k++) begin
        if (wr_sel[k]) begin
          port_out_data[k*DATA_W +: DATA_W] <= cpu_wr_data;
        end
      end
    end
  end

  // A strobe coinciding with a read of the same port hands the old value to the
  // reader and keeps the new one valid, so it is not an overrun.
  always_comb begin
    valid_nxt   = in_valid;
    overrun_nxt = status_wr ? '0 : overrun;
    for (int k = 0; k < N_PORTS; k++) begin
      if (port_in_strobe[k]) begin
        valid_nxt[k] = 1'b1;
        if (in_valid[k] && !rd_sel[k]) begin
          overrun_nxt[k] = 1'b1;
        end
      end else if (rd_sel[k]) begin
        valid_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_latch <= '0;
      in_valid <= '0;
      overrun  <= '0;
    end else begin
      in_valid <= valid_nxt;
      overrun  <= overrun_nxt;
      for (int k = 0; k < N_PORTS; k++) begin
        if (port_in_strobe[k]) begin
          in_latch[k*DATA_W +: DATA_W] <= port_in_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    status_word    = '0;
    status_word[0] = halted;
    status_word[1] = timeout;
    status_word[2] = |overrun;
    valid_word     = '0;
    valid_word[VALID_W-1:0] = in_valid[VALID_W-1:0];
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (cpu_addr == ADDR_W'(k)) begin
        rd_word = in_latch[k*DATA_W +: DATA_W];
      end
    end
    if (cpu_addr == STATUS_ADDR) begin
      rd_word = status_word;
    end
    if (cpu_addr == VALID_ADDR) begin
      rd_word = valid_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rd_data  <= '0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= cpu_rd_en;
      if (cpu_rd_en) begin
        cpu_rd_data <= rd_word;
      end
    end
  end

  // Watchdog counts from reset release and parks on its last value once expired.
  assign wd_run = (WDOG_CYCLES != 0) && !halted && !timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_count <= '0;
      timeout  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      if (halt_req) begin
        halted <= 1'b1;
      end
      if (wd_run) begin
        if (wd_count == WD_LAST) begin
          timeout <= 1'b1;
        end else begin
          wd_count <= wd_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed scenarios plus randomized traffic, every cycle
// compared against an array-based reference model of the port bank.
module tb_io_port_bank;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int HP = 15;
  localparam int WD = 20;
  localparam int AW = $clog2(N + 2);

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   cpu_addr;
  logic            cpu_wr_en;
  logic [W-1:0]    cpu_wr_data;
  logic            cpu_rd_en;
  logic [W-1:0]    cpu_rd_data;
  logic            cpu_rd_valid;
  logic [N*W-1:0]  port_in_data;
  logic [N-1:0]    port_in_strobe;
  logic [N*W-1:0]  port_out_data;
  logic [N-1:0]    port_out_update;
  logic            halted;
  logic            timeout;

  io_port_bank #(.N_PORTS(N), .DATA_W(W), .HALT_PORT(HP), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid), .port_in_data(port_in_data), .port_in_strobe(port_in_strobe),
    .port_out_data(port_out_data), .port_out_update(port_out_update),
    .halted(halted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_out   [N];
  logic [W-1:0] m_latch [N];
  bit           m_valid [N];
  bit           m_ovr   [N];
  bit           m_halted, m_timeout;
  int           m_run;
  logic [N-1:0] m_upd;
  bit           m_rdv;
  logic [W-1:0] m_rdd;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_out[k] = '0; m_latch[k] = '0; m_valid[k] = 0; m_ovr[k] = 0;
    end
    m_halted = 0; m_timeout = 0; m_run = 0;
    m_upd = '0; m_rdv = 0; m_rdd = '0;
  endtask

  // Next state from the current model state and the inputs about to be sampled.
  task automatic model_step();
    int a;
    bit was_halted;
    bit any_ovr;
    bit new_ovr [N];
    logic [W-1:0] rv;
    if (reset) begin
      model_reset();
      return;
    end
    a = int'(cpu_addr);
    was_halted = m_halted;
    any_ovr = 0;
    for (int k = 0; k < N; k++) any_ovr |= m_ovr[k];
    m_rdv = cpu_rd_en;
    if (cpu_rd_en) begin
      rv = '0;
      if (a < N) rv = m_latch[a];
      else if (a == N) rv = W'({any_ovr, m_timeout, m_halted});
      else if (a == N + 1) for (int i = 0; i < W && i < N; i++) rv[i] = m_valid[i];
      m_rdd = rv;
    end
    if (!was_halted && !m_timeout) begin
      m_run++;
      if (m_run >= WD) m_timeout = 1;
    end
    for (int k = 0; k < N; k++) begin
      bit rd_hit;
      rd_hit = cpu_rd_en && (a == k);
      new_ovr[k] = 0;
      if (port_in_strobe[k]) begin
        if (m_valid[k] && !rd_hit) new_ovr[k] = 1;
        m_latch[k] = port_in_data[k*W +: W];
        m_valid[k] = 1;
      end else if (rd_hit) begin
        m_valid[k] = 0;
      end
    end
    m_upd = '0;
    if (cpu_wr_en && !was_halted) begin
      if (a < N) begin
        m_out[a] = cpu_wr_data;
        m_upd[a] = 1'b1;
        if (a == HP && cpu_wr_data[0]) m_halted = 1;
      end else if (a == N) begin
        for (int k = 0; k < N; k++) m_ovr[k] = 0;
      end
    end
    for (int k = 0; k < N; k++) m_ovr[k] |= new_ovr[k];
  endtask

  task automatic compare_all();
    logic [N*W-1:0] e;
    for (int k = 0; k < N; k++) e[k*W +: W] = m_out[k];
    check_val("out_data", port_out_data, e);
    check_val("out_update", port_out_update, m_upd);
    check_val("halted", halted, m_halted);
    check_val("timeout", timeout, m_timeout);
    check_val("rd_valid", cpu_rd_valid, m_rdv);
    if (m_rdv) check_val("rd_data", cpu_rd_data, m_rdd);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cpu_addr = '0; cpu_wr_en = 0; cpu_wr_data = '0; cpu_rd_en = 0;
    port_in_strobe = '0; port_in_data = '0;
  endtask

  // Reset lands between edges with whatever inputs are pending (possibly a read).
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    check_val("rst_rd_data", cpu_rd_data, 8'h00);
    step();
    idle();
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    cpu_wr_en   = ($urandom % 4) == 0;
    cpu_rd_en   = ($urandom % 3) == 0;
    cpu_addr    = (($urandom % 8) == 0) ? AW'($urandom_range(N + 2, (1 << AW) - 1))
                                        : AW'($urandom_range(0, N + 1));
    cpu_wr_data = W'($urandom);
    if (int'(cpu_addr) == HP && ($urandom % 8) != 0) cpu_wr_data[0] = 1'b0;
    port_in_strobe = N'($urandom & $urandom);
    port_in_data   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check_val("rst_rd_data", cpu_rd_data, 8'h00);
    reset = 1'b0;

    // Watchdog: rises on the 20th edge after release
    for (int i = 1; i <= 22; i++) begin
      step();
      check_val("wdog_edge", timeout, i >= WD);
      if (i == 5) check_val("halted_early", halted, 1'b0);
    end
    cpu_rd_en = 1; cpu_addr = AW'(N);
    step();
    check_val("status_timeout", cpu_rd_data, 8'h02);
    do_reset(1);
    check_val("rst_clears_to", timeout, 1'b0);
    repeat (10) step();
    do_reset(1);
    for (int i = 1; i <= WD; i++) begin
      step();
      check_val("wdog_restart", timeout, i >= WD);
    end

    // Port write and update pulse
    do_reset(2);
    cpu_wr_en = 1; cpu_addr = 3; cpu_wr_data = 8'hA5;
    step();
    check_val("wr3_data", port_out_data[31:24], 8'hA5);
    check_val("wr3_update", port_out_update, 16'h0008);
    check_val("wr3_others", port_out_data & ~(128'hFF << 24), 128'h0);
    idle();
    step();
    check_val("wr3_pulse_end", port_out_update, 16'h0000);

    // Strobe, read with latency, valid cleared by read
    port_in_strobe = 16'h0004; port_in_data[23:16] = 8'h3C;
    step();
    idle();
    cpu_rd_en = 1; cpu_addr = AW'(N + 1);
    step();
    check_val("valid_before", cpu_rd_data, 8'h04);
    cpu_addr = 2;
    step();
    check_val("rd2_valid", cpu_rd_valid, 1'b1);
    check_val("rd2_data", cpu_rd_data, 8'h3C);
    cpu_addr = AW'(N + 1);
    step();
    check_val("valid_after", cpu_rd_data, 8'h00);
    idle();
    step();
    check_val("rd_pulse_end", cpu_rd_valid, 1'b0);

    // Overrun, STATUS read concurrent with the clearing write
    do_reset(1);
    port_in_strobe = 16'h0020; port_in_data[47:40] = 8'h11;
    step();
    port_in_data[47:40] = 8'h22;
    step();
    idle();
    cpu_rd_en = 1; cpu_addr = AW'(N);
    step();
    check_val("status_ovr", cpu_rd_data, 8'h04);
    cpu_addr = 5;
    step();
    check_val("rd5_data", cpu_rd_data, 8'h22);
    cpu_addr = AW'(N); cpu_wr_en = 1; cpu_wr_data = 8'hFF;
    step();
    check_val("status_prewrite", cpu_rd_data, 8'h04);
    cpu_wr_en = 0;
    step();
    check_val("status_cleared", cpu_rd_data, 8'h00);

    // Read and strobe of the same port in one cycle
    do_reset(1);
    port_in_strobe = 16'h0080; port_in_data[63:56] = 8'h10;
    step();
    port_in_data[63:56] = 8'h20; cpu_rd_en = 1; cpu_addr = 7;
    step();
    check_val("rdstb_old", cpu_rd_data, 8'h10);
    idle();
    cpu_rd_en = 1; cpu_addr = AW'(N);
    step();
    check_val("rdstb_no_ovr", cpu_rd_data, 8'h00);
    cpu_addr = AW'(N + 1);
    step();
    check_val("rdstb_valid", cpu_rd_data, 8'h80);
    cpu_addr = AW'(N + 5); cpu_wr_en = 1; cpu_wr_data = 8'h5A;
    step();
    check_val("rd_oob", cpu_rd_data, 8'h00);

    // Halt, then writes are ignored
    do_reset(1);
    cpu_wr_en = 1; cpu_addr = AW'(HP); cpu_wr_data = 8'h01;
    step();
    check_val("halt_set", halted, 1'b1);
    check_val("halt_port", port_out_data[127:120], 8'h01);
    cpu_addr = 0; cpu_wr_data = 8'h77;
    step();
    check_val("halt_wr_ignored", port_out_data[7:0], 8'h00);
    check_val("halt_no_update", port_out_update, 16'h0000);
    idle();
    repeat (25) step();
    check_val("halt_wdog_frozen", timeout, 1'b0);

    // Randomized traffic with periodic resets
    for (int seg = 0; seg < 12; seg++) begin
      randomize_inputs();
      do_reset(int'($urandom_range(0, 2)));
      for (int c = 0; c < 60; c++) begin
        randomize_inputs();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
